wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback path and the long-latency unit (MUL/DIV) completion path.
- Long-latency results are buffered in a small FIFO. They drain when the pipeline has no writeback, or when a starvation limit or a full FIFO forces priority.
- Sits between the writeback-data mux output and the register file; stalls the pipeline when it loses arbitration.
- Also reports whether a source register has a buffered result still pending, for hazard detection.

---
 rtl/wb_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the
// pipeline writeback path and buffered long-latency (MUL/DIV) results.
module wb_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_rd,
  input  logic [XLEN-1:0]               lu_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  output logic                          wb_stall,
  input  logic [4:0]                    query_rs1,
  input  logic [4:0]                    query_rs2,
  output logic                          rs1_pending,
  output logic                          rs2_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        mem_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]   mem_data [FIFO_DEPTH];

  logic empty;
  logic full;
  logic wb_req;
  logic lu_xfer;
  logic lu_keep;
  logic fifo_grant;
  logic push;
  logic pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign lu_ready   = !rst && !full;
  assign wb_req     = !rst && wb_valid && (wb_rd != 5'd0);
  assign lu_xfer    = lu_valid && lu_ready;
  // Results to x0 complete the handshake but are discarded.
  assign lu_keep    = lu_xfer && (lu_rd != 5'd0);
  assign fifo_count = count;

  // Grant selection and write-port mux.
  always_comb begin
    rf_we      = 1'b0;
    rf_rd      = 5'd0;
    rf_wdata   = '0;
    wb_stall   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    fifo_grant = 1'b0;
    if (!rst) begin
      if (empty) begin
        if (wb_req) begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd;
          rf_wdata = wb_data;
          push     = lu_keep;
        end else if (lu_keep) begin
          // Bypass straight to the register file; nothing is buffered.
          rf_we    = 1'b1;
          rf_rd    = lu_rd;
          rf_wdata = lu_data;
        end
      end else begin
        fifo_grant = !wb_req || (wait_cnt == WAIT_W'(MAX_WAIT)) || full;
        push       = lu_keep;
        if (fifo_grant) begin
          pop      = 1'b1;
          rf_we    = (mem_rd[rd_ptr] != 5'd0);
          rf_rd    = mem_rd[rd_ptr];
          rf_wdata = mem_data[rd_ptr];
          wb_stall = wb_req;
        end else begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd;
          rf_wdata = wb_data;
        end
      end
    end
  end

  // Pointer, occupancy and starvation-counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (empty || fifo_grant) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Buffer storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= lu_rd;
      mem_data[wr_ptr] <= lu_data;
    end
  end

  // Hazard lookup across every valid buffered entry, head included.
  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    if (!rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if (CNT_W'(k) < count) begin
          if ((query_rs1 != 5'd0) && (mem_rd[PTR_W'(rd_ptr + PTR_W'(k))] == query_rs1))
            rs1_pending = 1'b1;
          if ((query_rs2 != 5'd0) && (mem_rd[PTR_W'(rd_ptr + PTR_W'(k))] == query_rs2))
            rs2_pending = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [2:0]  fifo_count;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_stall;
    logic        e_ready;
    logic        e_p1;
    logic        e_p2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic [4:0] q1, input logic [4:0] q2,
                     input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd,
                     input logic e_stall, input logic e_ready, input logic e_p1,
                     input logic e_p2, input logic [2:0] e_cnt);
    vec_t v;
    v.rst = r; v.wv = wv; v.wrd = wrd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.q1 = q1; v.q2 = q2; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_p1 = e_p1; v.e_p2 = e_p2; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] q1, input logic [4:0] q2);
    rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld; query_rs1 = q1; query_rs2 = q2;
  endtask

  initial begin
    int got;
    //  rst wv wrd wd       lv lrd ld        q1 q2  we rd wdata     st rdy p1 p2 cnt
    add(0, 0, 0, 0,        0, 0,  0,         0, 0,  0, 0, 0,        0, 1, 0, 0, 0); // idle
    add(0, 0, 0, 0,        1, 5,  32'h1234,  5, 0,  1, 5, 32'h1234, 0, 1, 0, 0, 0); // bypass
    add(0, 0, 0, 0,        0, 0,  0,         5, 0,  0, 0, 0,        0, 1, 0, 0, 0);
    add(0, 1, 3, 32'hA,    1, 7,  32'hB,     7, 0,  1, 3, 32'hA,    0, 1, 0, 0, 0); // collision
    add(0, 0, 0, 0,        0, 0,  0,         7, 7,  1, 7, 32'hB,    0, 1, 1, 1, 1); // drain head
    add(0, 0, 0, 0,        0, 0,  0,         7, 0,  0, 0, 0,        0, 1, 0, 0, 0);
    add(0, 1, 3, 32'h10,   1, 9,  32'h99,    0, 0,  1, 3, 32'h10,   0, 1, 0, 0, 0); // starvation
    add(0, 1, 4, 32'h20,   0, 0,  0,         9, 0,  1, 4, 32'h20,   0, 1, 1, 0, 1);
    add(0, 1, 4, 32'h21,   0, 0,  0,         0, 9,  1, 4, 32'h21,   0, 1, 0, 1, 1);
    add(0, 1, 4, 32'h22,   0, 0,  0,         0, 0,  1, 4, 32'h22,   0, 1, 0, 0, 1);
    add(0, 1, 4, 32'h23,   0, 0,  0,         0, 0,  1, 9, 32'h99,   1, 1, 0, 0, 1); // forced
    add(0, 1, 4, 32'h23,   0, 0,  0,         0, 0,  1, 4, 32'h23,   0, 1, 0, 0, 0); // retry
    add(0, 0, 0, 0,        1, 0,  32'h55,    0, 0,  0, 0, 0,        0, 1, 0, 0, 0); // lu x0
    add(0, 0, 0, 0,        0, 0,  0,         0, 0,  0, 0, 0,        0, 1, 0, 0, 0);
    add(0, 1, 2, 32'h1,    1, 1,  32'h101,   0, 0,  1, 2, 32'h1,    0, 1, 0, 0, 0); // fill
    add(0, 1, 2, 32'h2,    1, 2,  32'h102,   0, 0,  1, 2, 32'h2,    0, 1, 0, 0, 1);
    add(0, 1, 2, 32'h3,    1, 3,  32'h103,   0, 0,  1, 2, 32'h3,    0, 1, 0, 0, 2);
    add(0, 1, 2, 32'h4,    1, 4,  32'h104,   0, 0,  1, 2, 32'h4,    0, 1, 0, 0, 3);
    add(0, 1, 2, 32'h5,    1, 5,  32'h105,   1, 4,  1, 1, 32'h101,  1, 0, 1, 1, 4); // full
    add(0, 0, 0, 0,        1, 5,  32'h105,   1, 5,  1, 2, 32'h102,  0, 1, 0, 0, 3); // push+pop
    add(0, 0, 0, 0,        0, 0,  0,         5, 0,  1, 3, 32'h103,  0, 1, 1, 0, 3);
    add(0, 1, 0, 32'h77,   0, 0,  0,         0, 0,  1, 4, 32'h104,  0, 1, 0, 0, 2); // wb x0
    add(0, 1, 6, 32'h66,   0, 0,  0,         0, 0,  1, 6, 32'h66,   0, 1, 0, 0, 1);
    add(0, 1, 6, 32'h67,   1, 10, 32'hA0,    0, 0,  1, 6, 32'h67,   0, 1, 0, 0, 1);
    add(0, 1, 6, 32'h68,   1, 11, 32'hB0,    10, 0, 1, 6, 32'h68,   0, 1, 1, 0, 2);
    add(1, 1, 6, 32'h69,   1, 12, 32'hC0,    5, 10, 0, 0, 0,        0, 0, 0, 0, 3); // rst @3
    add(0, 0, 0, 0,        0, 0,  0,         5, 10, 0, 0, 0,        0, 1, 0, 0, 0);

    // Initial reset, checked while held.
    drive(1, 1, 3, 32'h5, 1, 4, 32'h6, 4, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(wb_stall), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd0);
    chk("rst_pend", 32'({rs1_pending, rs2_pending}), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].lv,
            vecs[i].lrd, vecs[i].ld, vecs[i].q1, vecs[i].q2);
      #2;
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wd);
      end
      chk($sformatf("v%0d_stall", i), 32'(wb_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_p1", i), 32'(rs1_pending), 32'(vecs[i].e_p1));
      chk($sformatf("v%0d_p2", i), 32'(rs2_pending), 32'(vecs[i].e_p2));
      chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
    end

    // Ordering: buffer rd 1..4 behind a pipeline stream, then drain in a bounded window.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1, 20, 32'h300 + 32'(i), 1, 5'(i + 1), 32'h200 + 32'(i), 0, 0);
      #2;
      chk($sformatf("fill%0d_rd", i), 32'(rf_rd), 32'd20);
    end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      if (rf_we) begin
        chk($sformatf("drain%0d_rd", got), 32'(rf_rd), 32'(got + 1));
        chk($sformatf("drain%0d_wdata", got), rf_wdata, 32'h200 + 32'(got));
        got++;
      end
    end
    chk("drain_total", 32'(got), 32'd4);
    chk("drain_cnt", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
